// File: rtl/weight_update_unit_if.sv
// Port bundle for weight_update_unit: the gradient-update stream, the
// update control/status, and the independent weight read port.
interface weight_update_unit_if #(
  parameter int data_size   = 8,
  parameter int size        = 3,
  parameter int index_width = 33
);
  logic                          update_start;
  logic [index_width-1:0]        update_layer_index;
  logic                          dc_dw_valid;
  logic [data_size*size-1:0]     dc_dw_stream;
  logic [index_width-1:0]        rd_layer_index;
  logic [$clog2(size)-1:0]       rd_row;
  logic [data_size*size-1:0]     weight_row_out;
  logic                          busy;
  logic                          update_done;
  logic                          update_err;

  modport master (
    output update_start, update_layer_index, dc_dw_valid, dc_dw_stream,
    output rd_layer_index, rd_row,
    input  weight_row_out, busy, update_done, update_err
  );

  modport slave (
    input  update_start, update_layer_index, dc_dw_valid, dc_dw_stream,
    input  rd_layer_index, rd_row,
    output weight_row_out, busy, update_done, update_err
  );
endinterface

// File: rtl/weight_update_unit.sv
// On-chip weight store updated as w <= w - (g >>> LR_SHIFT) row by row, with a registered read port.
// Define UPDATE_SATURATE_EN to clamp results; otherwise results wrap to data_size bits.
module weight_update_unit #(
  parameter int data_size      = 8,
  parameter int size           = 3,
  parameter int max_layer_size = 4,
  parameter int LR_SHIFT       = 2,
  parameter int index_width    = 33
) (
  input logic                  clk,
  input logic                  reset,
  weight_update_unit_if.slave  bus
);

  localparam int row_w    = $clog2(size);
  localparam int layer_w  = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int row_bits = data_size * size;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                      state;
  logic [layer_w-1:0]          layer_q;
  logic [row_w-1:0]            row_cnt;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_q;
  logic signed [data_size-1:0] w [max_layer_size][size][size];
  logic [row_bits-1:0]         rd_word_p0;
  logic [row_bits-1:0]         rd_word_p1;
  logic                        start_ok;
  logic                        last_row;
  logic                        rd_ok;
  logic [layer_w-1:0]          rd_layer;

  function automatic logic signed [data_size-1:0] narrow(input logic signed [data_size:0] diff);
`ifdef UPDATE_SATURATE_EN
    if (diff[data_size] != diff[data_size-1])
      narrow = diff[data_size] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
    else
      narrow = diff[data_size-1:0];
`else
    narrow = diff[data_size-1:0];
`endif
  endfunction

  // Difference is formed one bit wider so it can never overflow before narrowing.
  function automatic logic signed [data_size-1:0] apply_grad(input logic signed [data_size-1:0] wv,
                                                             input logic signed [data_size-1:0] g);
    logic signed [data_size-1:0] delta;
    logic signed [data_size:0]   diff;
    delta = g >>> LR_SHIFT;
    diff  = {wv[data_size-1], wv} - {delta[data_size-1], delta};
    return narrow(diff);
  endfunction

  assign start_ok = bus.update_layer_index < index_width'(max_layer_size);
  assign last_row = (row_cnt == row_w'(size - 1));
  assign rd_ok    = (bus.rd_layer_index < index_width'(max_layer_size)) &&
                    ({1'b0, bus.rd_row} < (row_w + 1)'(size));
  assign rd_layer = bus.rd_layer_index[layer_w-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      layer_q <= '0;
      row_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.update_start) begin
            if (start_ok) begin
              state   <= UPDATE;
              layer_q <= bus.update_layer_index[layer_w-1:0];
              row_cnt <= '0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        UPDATE: begin
          if (bus.dc_dw_valid) begin
            if (last_row) begin
              state   <= DONE;
              done_q  <= 1'b1;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < max_layer_size; l++)
        for (int r = 0; r < size; r++)
          for (int j = 0; j < size; j++)
            w[l][r][j] <= '0;
    end else if (state == UPDATE && bus.dc_dw_valid) begin
      for (int j = 0; j < size; j++)
        w[layer_q][row_cnt][j] <= apply_grad(w[layer_q][row_cnt][j],
                                             $signed(bus.dc_dw_stream[(size-j)*data_size-1 -: data_size]));
    end
  end

  // Stage p0: combinational row select from the store (pre-write contents).
  always_comb begin
    rd_word_p0 = '0;
    if (rd_ok)
      for (int j = 0; j < size; j++)
        rd_word_p0[(size-j)*data_size-1 -: data_size] = w[rd_layer][bus.rd_row][j];
  end

  // Stage p1: registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_word_p1 <= '0;
    else       rd_word_p1 <= rd_word_p0;
  end

  assign bus.weight_row_out = rd_word_p1;
  assign bus.busy           = busy_q;
  assign bus.update_done    = done_q;
  assign bus.update_err     = err_q;

endmodule

// File: tb/tb_weight_update_unit.sv
// Scoreboard bench for weight_update_unit: stimulus queues expected read rows and status
// flags against a plain-arithmetic weight model; a negedge monitor pops and compares.
module tb_weight_update_unit;
  localparam int DW = 8;
  localparam int SZ = 3;
  localparam int NL = 4;
  localparam int IW = 33;

  typedef int grad_t [3][3];

  logic clk = 1'b0;
  logic reset = 1'b1;

  weight_update_unit_if #(.data_size(DW), .size(SZ), .index_width(IW)) bus ();

  weight_update_unit #(
    .data_size(DW), .size(SZ), .max_layer_size(NL), .LR_SHIFT(2), .index_width(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mw [4][3][3];
  logic [23:0] rd_q [$];
  logic [2:0]  ctl_q [$];
  bit do_rd = 0, rd_req = 0, ctl_req = 0, rd_pend = 0, ctl_pend = 0;

  always @(posedge clk) begin
    rd_pend  <= rd_req;
    ctl_pend <= ctl_req;
  end

  always @(negedge clk) begin
    logic [23:0] er;
    logic [2:0]  ec;
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_row: got %h with no expected row queued", bus.weight_row_out);
      end else begin
        er = rd_q.pop_front();
        if (bus.weight_row_out !== er) begin
          errors++;
          $display("FAIL rd_row at %0t: got %h expected %h", $time, bus.weight_row_out, er);
        end
      end
    end
    if (ctl_pend) begin
      checks++;
      if (ctl_q.size() == 0) begin
        errors++;
        $display("FAIL status: no expected status queued");
      end else begin
        ec = ctl_q.pop_front();
        if ({bus.busy, bus.update_done, bus.update_err} !== ec) begin
          errors++;
          $display("FAIL status at %0t: busy/done/err got %b%b%b expected %b",
                   $time, bus.busy, bus.update_done, bus.update_err, ec);
        end
      end
    end
  end

  function automatic int model_upd(input int wv, input int g);
    int d;
    int diff;
    d = g >>> 2;
    diff = wv - d;
`ifdef UPDATE_SATURATE_EN
    if (diff > 127) return 127;
    if (diff < -128) return -128;
    return diff;
`else
    return ((diff + 128) & 255) - 128;
`endif
  endfunction

  function automatic logic [23:0] exp_row(input logic [32:0] l, input logic [1:0] r);
    logic [23:0] v;
    v = '0;
    if (l < 33'd4 && r < 2'd3)
      for (int j = 0; j < 3; j++) v[(3-j)*8-1 -: 8] = 8'(mw[int'(l[1:0])][int'(r)][j]);
    return v;
  endfunction

  function automatic logic [23:0] pack(input int a, input int b, input int c);
    return {8'(a), 8'(b), 8'(c)};
  endfunction

  task automatic tick(input bit chk_ctl, input bit eb, input bit ed, input bit ee);
    if (do_rd) rd_q.push_back(exp_row(bus.rd_layer_index, bus.rd_row));
    rd_req = do_rd;
    if (chk_ctl) ctl_q.push_back({eb, ed, ee});
    ctl_req = chk_ctl;
    @(posedge clk); #1;
  endtask

  task automatic tick_exp(input logic [32:0] l, input logic [1:0] r, input logic [23:0] e);
    bus.rd_layer_index = l;
    bus.rd_row = r;
    rd_q.push_back(e);
    rd_req = 1;
    ctl_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic rand_rd();
    do_rd = 1;
    bus.rd_layer_index = ($urandom_range(0, 7) == 0) ? 33'($urandom_range(4, 9)) : 33'($urandom_range(0, 3));
    bus.rd_row = 2'($urandom_range(0, 3));
  endtask

  task automatic read_all();
    do_rd = 1;
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 3; r++) begin
        bus.rd_layer_index = 33'(l);
        bus.rd_row = 2'(r);
        tick(1, 0, 0, 0);
      end
    bus.rd_layer_index = 33'd4;        bus.rd_row = 2'd0; tick(1, 0, 0, 0);
    bus.rd_layer_index = 33'h1_0000_0001; bus.rd_row = 2'd1; tick(1, 0, 0, 0);
    bus.rd_layer_index = 33'd0;        bus.rd_row = 2'd3; tick(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.update_start = 0;
    bus.dc_dw_valid = 0;
    do_rd = 0;
    tick(0, 0, 0, 0);
    reset = 1;
    #2;
    checks++;
    if ({bus.busy, bus.update_done, bus.update_err} !== 3'b000 || bus.weight_row_out !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: busy/done/err %b%b%b row %h expected 000 and 000000",
               bus.busy, bus.update_done, bus.update_err, bus.weight_row_out);
    end
    foreach (mw[l, r, j]) mw[l][r][j] = 0;
    tick(1, 0, 0, 0);
    reset = 0;
    tick(1, 0, 0, 0);
  endtask

  task automatic do_update(input logic [32:0] layer, input grad_t g, input int gaps, input bit inject);
    bit ok;
    ok = layer < 33'd4;
    bus.update_start = 1;
    bus.update_layer_index = layer;
    bus.dc_dw_valid = 1'($urandom_range(0, 1));
    bus.dc_dw_stream = 24'($urandom);
    rand_rd();
    tick(1, ok, 0, !ok);
    bus.update_start = 0;
    bus.dc_dw_valid = 0;
    if (!ok) begin
      rand_rd();
      tick(1, 0, 0, 0);
      return;
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ((r > 0) ? gaps : 0); k++) begin
        bus.dc_dw_valid = 0;
        bus.update_start = inject;
        bus.update_layer_index = 33'd2;
        rand_rd();
        tick(1, 1, 0, 0);
        bus.update_start = 0;
      end
      bus.dc_dw_valid = 1;
      bus.dc_dw_stream = pack(g[r][0], g[r][1], g[r][2]);
      rand_rd();
      tick(1, 1, r == 2, 0);
      for (int j = 0; j < 3; j++)
        mw[int'(layer[1:0])][r][j] = model_upd(mw[int'(layer[1:0])][r][j], g[r][j]);
    end
    bus.dc_dw_valid = 0;
    bus.update_start = inject;
    bus.update_layer_index = 33'd2;
    rand_rd();
    tick(1, 0, 0, 0);
    bus.update_start = 0;
    rand_rd();
    tick(1, 0, 0, 0);
  endtask

  initial begin
    grad_t t1, t2, ts, gr;
    logic [23:0] sat_row;
    logic [32:0] lay;
    t1 = '{'{8, -8, 4}, '{0, 1, -4}, '{12, -12, 3}};
    t2 = '{'{-40, 20, 7}, '{100, -100, 1}, '{-3, 5, 64}};
    ts = '{'{127, -128, 0}, '{0, 0, 0}, '{0, 0, 0}};
`ifdef UPDATE_SATURATE_EN
    sat_row = {8'h80, 8'h7f, 8'h00};
`else
    sat_row = {8'd101, 8'hA0, 8'h00};
`endif
    bus.update_start = 0;
    bus.update_layer_index = '0;
    bus.dc_dw_valid = 0;
    bus.dc_dw_stream = '0;
    bus.rd_layer_index = '0;
    bus.rd_row = '0;
    @(posedge clk); #1;
    do_reset();
    read_all();

    // Back-to-back rows on layer 1; independent constant readback.
    do_update(33'd1, t1, 0, 0);
    read_all();
    tick_exp(33'd1, 2'd0, {8'hFE, 8'h02, 8'hFF});
    tick_exp(33'd1, 2'd1, {8'h00, 8'h00, 8'h01});
    tick_exp(33'd1, 2'd2, {8'hFD, 8'h03, 8'h00});

    // Same update with two stall cycles between rows.
    do_reset();
    do_update(33'd1, t1, 2, 0);
    read_all();
    tick_exp(33'd1, 2'd0, {8'hFE, 8'h02, 8'hFF});

    // Out-of-range starts, then a start on layer 2 issued while busy on layer 1.
    do_update(33'd4, t2, 0, 0);
    do_update(33'h1_0000_0002, t2, 0, 0);
    do_update(33'd1, t2, 1, 1);
    read_all();

    // Repeated large gradient on layer 0 row 0 exercises saturation/wrap.
    do_reset();
    for (int n = 0; n < 5; n++) do_update(33'd0, ts, 0, 0);
    tick_exp(33'd0, 2'd0, sat_row);
    read_all();

    // Reset arriving after the second row of an update.
    bus.update_start = 1;
    bus.update_layer_index = 33'd3;
    rand_rd();
    tick(1, 1, 0, 0);
    bus.update_start = 0;
    for (int r = 0; r < 2; r++) begin
      bus.dc_dw_valid = 1;
      bus.dc_dw_stream = pack(60, -60, 33);
      rand_rd();
      tick(1, 1, 0, 0);
      mw[3][r][0] = model_upd(mw[3][r][0], 60);
      mw[3][r][1] = model_upd(mw[3][r][1], -60);
      mw[3][r][2] = model_upd(mw[3][r][2], 33);
    end
    do_reset();
    do_rd = 0;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    read_all();

    // Randomized updates with idle-cycle garbage on the stream.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        6: lay = 33'd4;
        7: lay = 33'h1_0000_0000 | 33'($urandom_range(0, 3));
        default: lay = 33'($urandom_range(0, 3));
      endcase
      foreach (gr[r, j]) gr[r][j] = int'($urandom_range(0, 255)) - 128;
      do_update(lay, gr, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        bus.dc_dw_valid = 1;
        bus.dc_dw_stream = 24'($urandom);
        rand_rd();
        tick(1, 0, 0, 0);
      end
      bus.dc_dw_valid = 0;
    end
    read_all();

    do_rd = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (rd_q.size() != 0 || ctl_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d rows and %0d status entries left, expected 0 and 0",
               rd_q.size(), ctl_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
